// File: rtl/triangle_monitor_if.sv
// Sample bus carrying the triangle waveform into the monitor.
// The source drives the master side and the monitor listens on the slave side.
interface triangle_monitor_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] sample_in;
   logic             sample_valid;

   modport master (output sample_in, output sample_valid);
   modport slave  (input  sample_in, input  sample_valid);
endinterface

// File: rtl/triangle_monitor.sv
// Receive-side checker for a 0 -> PEAK -> 0 triangle waveform. It tracks the
// slope, flags peaks and troughs, measures the period, counts errors and declares lock.
module triangle_monitor #(
   parameter int WIDTH        = 8,
   parameter int PEAK         = 127,
   parameter int PERIOD_W     = 16,
   parameter int LOCK_PERIODS = 2
) (
   input  logic                clk,
   input  logic                reset,
   triangle_monitor_if.slave   bus,
   output logic                direction,
   output logic                peak_pulse,
   output logic                trough_pulse,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid,
   output logic                locked,
   output logic                error_pulse,
   output logic [7:0]          err_count
);
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DIR    = 2'd1;
   localparam logic [1:0] ST_TRACK  = 2'd2;
   localparam logic [1:0] ST_LOCKED = 2'd3;

   localparam int XW = WIDTH + 1;
   localparam logic [XW-1:0]       PEAK_X      = XW'(PEAK);
   localparam logic [XW-1:0]       ONE_X       = XW'(1);
   localparam logic [XW-1:0]       ZERO_X      = XW'(0);
   localparam logic [PERIOD_W-1:0] GOOD_PERIOD = PERIOD_W'(2 * PEAK);
   localparam logic [PERIOD_W-1:0] CNT_MAX     = {PERIOD_W{1'b1}};
   localparam logic [PERIOD_W-1:0] ONE_P       = PERIOD_W'(1);
   localparam logic [3:0]          LOCK_TARGET = 4'(LOCK_PERIODS);

   logic [1:0]          state,       state_nxt;
   logic [WIDTH-1:0]    ref_val,     ref_nxt;
   logic                trough_seen, seen_nxt;
   logic [PERIOD_W-1:0] cnt,         cnt_nxt;
   logic [3:0]          good,        good_nxt;
   logic                dir_nxt,     locked_nxt;
   logic [PERIOD_W-1:0] period_nxt;
   logic [7:0]          errc_nxt;
   logic                peak_hit, trough_hit, err_hit, pv_hit;

   // Extra top bit keeps ref+1 / ref-1 free of wrap-around aliasing.
   logic [XW-1:0]       s_ext, r_ext;
   logic                is_up, is_dn, out_of_range, at_peak, at_zero;
   logic [PERIOD_W-1:0] cnt_inc;
   logic [3:0]          good_inc;

   assign s_ext        = {1'b0, bus.sample_in};
   assign r_ext        = {1'b0, ref_val};
   assign is_up        = (s_ext == (r_ext + ONE_X));
   assign is_dn        = (s_ext == (r_ext - ONE_X));
   assign out_of_range = (s_ext > PEAK_X);
   assign at_peak      = (s_ext == PEAK_X);
   assign at_zero      = (s_ext == ZERO_X);
   assign cnt_inc      = (cnt == CNT_MAX) ? CNT_MAX : (cnt + ONE_P);
   assign good_inc     = (good == 4'hF) ? 4'hF : (good + 4'd1);

   // Next-state evaluation for one accepted sample.
   always_comb begin
      state_nxt  = state;
      ref_nxt    = ref_val;
      dir_nxt    = direction;
      seen_nxt   = trough_seen;
      cnt_nxt    = cnt;
      good_nxt   = good;
      period_nxt = period;
      locked_nxt = locked;
      errc_nxt   = err_count;
      peak_hit   = 1'b0;
      trough_hit = 1'b0;
      err_hit    = 1'b0;
      pv_hit     = 1'b0;

      if (bus.sample_valid) begin
         cnt_nxt = cnt_inc;
         ref_nxt = bus.sample_in;
         if (out_of_range) begin
            err_hit   = 1'b1;
            ref_nxt   = ref_val;
            state_nxt = ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  state_nxt = ST_DIR;
               end
               ST_DIR: begin
                  if (is_up) begin
                     state_nxt = ST_TRACK;
                     dir_nxt   = 1'b0;
                     peak_hit  = at_peak;
                  end else if (is_dn) begin
                     state_nxt  = ST_TRACK;
                     dir_nxt    = 1'b1;
                     trough_hit = at_zero;
                  end else begin
                     err_hit = 1'b1;
                  end
               end
               ST_TRACK, ST_LOCKED: begin
                  if (!direction && is_up) begin
                     peak_hit = at_peak;
                  end else if (direction && is_dn) begin
                     trough_hit = at_zero;
                  end else begin
                     err_hit   = 1'b1;
                     state_nxt = ST_DIR;
                  end
               end
               default: begin
                  state_nxt = ST_IDLE;
               end
            endcase
         end
      end else begin
         state_nxt = state;
      end

      if (peak_hit) begin
         dir_nxt = 1'b1;
      end else begin
         peak_hit = 1'b0;
      end

      if (err_hit) begin
         seen_nxt   = 1'b0;
         good_nxt   = 4'd0;
         locked_nxt = 1'b0;
         errc_nxt   = (err_count == 8'hFF) ? 8'hFF : (err_count + 8'd1);
      end else begin
         errc_nxt = err_count;
      end

      // A trough closes the running period only once a previous trough anchored it.
      if (trough_hit) begin
         dir_nxt  = 1'b0;
         cnt_nxt  = {PERIOD_W{1'b0}};
         seen_nxt = 1'b1;
         if (trough_seen) begin
            pv_hit     = 1'b1;
            period_nxt = cnt_inc;
            if (cnt_inc == GOOD_PERIOD) begin
               good_nxt = good_inc;
               if (good_inc >= LOCK_TARGET) begin
                  locked_nxt = 1'b1;
                  state_nxt  = ST_LOCKED;
               end else begin
                  locked_nxt = locked;
               end
            end else begin
               good_nxt   = 4'd0;
               locked_nxt = 1'b0;
               state_nxt  = ST_TRACK;
            end
         end else begin
            pv_hit = 1'b0;
         end
      end else begin
         trough_hit = 1'b0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         ref_val      <= {WIDTH{1'b0}};
         trough_seen  <= 1'b0;
         cnt          <= {PERIOD_W{1'b0}};
         good         <= 4'd0;
         direction    <= 1'b0;
         peak_pulse   <= 1'b0;
         trough_pulse <= 1'b0;
         period       <= {PERIOD_W{1'b0}};
         period_valid <= 1'b0;
         locked       <= 1'b0;
         error_pulse  <= 1'b0;
         err_count    <= 8'd0;
      end else begin
         state        <= state_nxt;
         ref_val      <= ref_nxt;
         trough_seen  <= seen_nxt;
         cnt          <= cnt_nxt;
         good         <= good_nxt;
         direction    <= dir_nxt;
         peak_pulse   <= peak_hit;
         trough_pulse <= trough_hit;
         period       <= period_nxt;
         period_valid <= pv_hit;
         locked       <= locked_nxt;
         error_pulse  <= err_hit;
         err_count    <= errc_nxt;
      end
   end
endmodule

// File: doc/triangle_monitor.md
# triangle_monitor

Receive-side checker for the 8-bit up/down triangle waveform produced by the team's triangle generator (0 → PEAK → 0, one step per sample). It tracks slope direction, flags peaks and troughs, measures the period in samples, and reports step errors. It declares lock after a configurable number of clean periods. It sits on the generator output, or on any bus carrying that waveform, as a self-check and monitoring block.

## Interface
- WIDTH, 8, sample width in bits
- PEAK, 127, top value of the waveform; the bottom value is 0
- PERIOD_W, 16, width of the period counter and `period` output
- LOCK_PERIODS, 2, number of consecutive good periods required to assert `locked` (1..15)
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low; clears all state and outputs
- sample_in  in  WIDTH  waveform sample
- sample_valid  in  1  sample_in is accepted on a cycle where this is high
- direction  out  1  0 = rising, 1 = falling; reset 0
- peak_pulse  out  1  one-cycle pulse when PEAK is accepted on a rising slope; reset 0
- trough_pulse  out  1  one-cycle pulse when 0 is accepted on a falling slope; reset 0
- period  out  PERIOD_W  last measured trough-to-trough sample count; reset 0
- period_valid  out  1  one-cycle pulse when `period` updates; reset 0
- locked  out  1  level; reset 0
- error_pulse  out  1  one-cycle pulse per illegal sample; reset 0
- err_count  out  8  saturating error count; reset 0

## Operation
- **States and transitions:**
  - IDLE: no reference sample is held.
  - DIR: a reference sample is held, but the direction is unknown.
  - TRACK: the direction is known, but the block is not yet locked.
  - LOCKED
- **Range check:** any accepted sample > PEAK is an error in every state.
  - In IDLE it is discarded and the block stays in IDLE.
  - In other states it causes a transition to IDLE.
- **IDLE:** a legal sample becomes the reference; go to DIR.
- **DIR:**
  - If ref is 0, only 1 is legal; it sets rising.
  - If ref is PEAK, only PEAK-1 is legal; it sets falling.
  - Otherwise, ref+1 sets rising and ref−1 sets falling.
  - A legal sample moves to TRACK. An illegal sample is an error; it becomes the new ref and the block stays in DIR.
- **TRACK/LOCKED, rising:**
  - The only legal next sample is ref+1.
  - Accepting PEAK on the rising slope pulses `peak_pulse` and sets `direction` to 1.
- **TRACK/LOCKED, falling:**
  - The only legal next sample is ref−1.
  - Accepting 0 on the falling slope pulses `trough_pulse` and sets `direction` to 0.
- **Error (TRACK/LOCKED):** pulse `error_pulse`. The sample becomes the new ref and the state goes to DIR. Clear the trough-seen flag, the good-period count and `locked`.
- **Period measurement:**
  - Each trough clears the sample counter to 0; the counter increments on each subsequent accepted sample.
  - At the next trough, `period` = counter+1 and `period_valid` pulses. No pulse is produced for the first trough after entering TRACK.
  - The counter saturates at all-ones.
- **Lock:**
  - On each `period_valid`, if period == 2·PEAK, increment the good count; otherwise clear the good count, drop `locked` and return to TRACK.
  - When the good count reaches LOCK_PERIODS, go to LOCKED.
- **err_count:** increments on every `error_pulse` and saturates at 255.
- **Samples with `sample_valid` low:** ignored entirely; no state change, and the period counter does not advance.

## Timing
- All outputs are registered. Any response to a sample accepted at edge N appears after edge N and is valid through N+1.
- The pulse outputs are high for exactly one cycle per accepted sample.
- `direction` updates in the same cycle as the peak/trough pulse. A clean period therefore produces `trough_pulse`, `period_valid` and possibly a `locked` rise in the same cycle.
- Back-to-back valid samples are supported (throughput of 1 sample per cycle). There is no backpressure.
- Reset asserted mid-operation immediately forces all outputs to their reset values. The first valid sample after reset release starts in IDLE.

## Test plan
- **Clean waveform:** after reset, drive 0,1,…,127,126,…,0 repeated three times, back-to-back.
  - `peak_pulse` fires on each 127.
  - `period_valid` fires with period=254 on the 2nd and 3rd trough.
  - `locked` rises at the 3rd trough.
  - err_count stays 0.
- **Step error while locked:** substitute 45 for 44 on a rising slope.
  - `error_pulse` fires once, err_count=1 and `locked` falls.
  - The next sample, 46, sets rising and the state goes to TRACK.
  - `locked` re-asserts two clean periods after the next trough.
- **Gapped input:** drive the same clean waveform with `sample_valid` low on random cycles (≈50% duty).
  - Expect identical period=254 and identical lock timing, counted in samples.
- **Mid-slope start:** after reset, feed 60,59,58,…
  - `direction`=1 after the second sample.
  - The first `trough_pulse` fires at 0 with no `period_valid`.
  - The first period=254 appears at the following trough.
- **Out-of-range and saturation:** feed 200.
  - `error_pulse` fires and the state stays IDLE.
  - After 300 consecutive 200s, err_count=255.
- **Reset mid-period:** assert reset while LOCKED.
  - All outputs go to 0 immediately.
  - After release, lock requires a full re-acquisition (3 troughs).
